// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control: load-use bubble, branch flush, memory-wait freeze with timeout.
// Optional saturating stall counter enabled by defining STALL_COUNTER_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  ifIdRs,
   input  logic [4:0]  ifIdRt,
   input  logic [4:0]  idExRt,
   input  logic        idExMemToReg,
   input  logic        branchTaken,
   input  logic        memBusy,
   output logic        pcWrite,
   output logic        ifIdWrite,
   output logic        ifIdFlush,
   output logic        idExFlush,
   output logic        pipeHold,
   output logic        memTimeout,
   output logic [1:0]  state,
   output logic [15:0] stallCount
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] FAULT    = 2'd2;
   localparam logic [7:0] TMO      = 8'(TIMEOUT);

   logic [1:0] stateQ;
   logic [7:0] waitCnt;
   logic       faultQ;
   logic       loadUse;
   logic       frozen;

   assign loadUse = idExMemToReg && (idExRt != 5'd0) &&
                    ((idExRt == ifIdRs) || (idExRt == ifIdRt));
   assign frozen  = (stateQ == FAULT) || memBusy;

   always_comb begin
      pcWrite   = 1'b1;
      ifIdWrite = 1'b1;
      ifIdFlush = 1'b0;
      idExFlush = 1'b0;
      pipeHold  = 1'b0;
      if (reset || frozen) begin
         pcWrite   = 1'b0;
         ifIdWrite = 1'b0;
         pipeHold  = 1'b1;
      end else if (branchTaken) begin
         ifIdFlush = 1'b1;
         idExFlush = 1'b1;
      end else if (loadUse) begin
         pcWrite   = 1'b0;
         ifIdWrite = 1'b0;
         idExFlush = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateQ  <= RUN;
         waitCnt <= 8'd0;
         faultQ  <= 1'b0;
      end else begin
         case (stateQ)
            RUN: begin
               if (memBusy) begin
                  stateQ  <= MEM_WAIT;
                  waitCnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (!memBusy) begin
                  stateQ  <= RUN;
                  waitCnt <= 8'd0;
               end else if (waitCnt < TMO) begin
                  waitCnt <= waitCnt + 8'd1;
               end else begin
                  stateQ <= FAULT;
                  faultQ <= 1'b1;
               end
            end
            FAULT: faultQ <= 1'b1;
            default: stateQ <= RUN;
         endcase
      end
   end

   assign state      = stateQ;
   assign memTimeout = faultQ;

`ifdef STALL_COUNTER_EN
   logic [15:0] stallCnt;

   // Counts every cycle the PC is held, saturating rather than wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stallCnt <= 16'd0;
      end else if (!pcWrite && (stallCnt != 16'hFFFF)) begin
         stallCnt <= stallCnt + 16'd1;
      end
   end

   assign stallCount = stallCnt;
`else
   assign stallCount = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  ifIdRs = '0;
   logic [4:0]  ifIdRt = '0;
   logic [4:0]  idExRt = '0;
   logic        idExMemToReg = 1'b0;
   logic        branchTaken = 1'b0;
   logic        memBusy = 1'b0;
   logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeHold;
   logic        memTimeout;
   logic [1:0]  state;
   logic [15:0] stallCount;

   int checks = 0;
   int failures = 0;

   // exp = {pcWrite,ifIdWrite,ifIdFlush,idExFlush,pipeHold,memTimeout,state}
   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] exRt;
      logic       m2r;
      logic       br;
      logic       busy;
      logic [7:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] exp;
      string      name;
   } sb_t;

   sb_t sbQ[$];
   vec_t vecs[10];

   pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
      .clock(clock),
      .reset(reset),
      .ifIdRs(ifIdRs),
      .ifIdRt(ifIdRt),
      .idExRt(idExRt),
      .idExMemToReg(idExMemToReg),
      .branchTaken(branchTaken),
      .memBusy(memBusy),
      .pcWrite(pcWrite),
      .ifIdWrite(ifIdWrite),
      .ifIdFlush(ifIdFlush),
      .idExFlush(idExFlush),
      .pipeHold(pipeHold),
      .memTimeout(memTimeout),
      .state(state),
      .stallCount(stallCount)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] outs();
      return {pcWrite, ifIdWrite, ifIdFlush, idExFlush,
              pipeHold, memTimeout, state};
   endfunction

   task automatic popCheck();
      sb_t e;
      logic [7:0] got;
      got = outs();
      checks++;
      if (sbQ.size() == 0) begin
         failures++;
         $display("FAIL scoreboard empty: got %b", got);
      end else begin
         e = sbQ.pop_front();
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", e.name, got, e.exp);
         end
      end
   endtask

   task automatic checkStall(input logic [15:0] want, input string nm);
      checks++;
      if (stallCount !== want) begin
         failures++;
         $display("FAIL %s: stallCount got %h required %h",
                  nm, stallCount, want);
      end
   endtask

   task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] exRt, input logic m2r,
                       input logic br, input logic busy,
                       input logic [7:0] exp, input string nm);
      sb_t e;
      @(posedge clock);
      #1;
      ifIdRs = rs;
      ifIdRt = rt;
      idExRt = exRt;
      idExMemToReg = m2r;
      branchTaken = br;
      memBusy = busy;
      e.exp = exp;
      e.name = nm;
      sbQ.push_back(e);
      @(negedge clock);
      popCheck();
   endtask

   task automatic idle(input logic [7:0] exp, input string nm);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp, nm);
   endtask

   task automatic busyCyc(input logic br, input logic [7:0] exp,
                          input string nm);
      step(5'd0, 5'd0, 5'd0, 1'b0, br, 1'b1, exp, nm);
   endtask

   task automatic resetNow(input string nm);
      sb_t e;
      #1;
      reset = 1'b1;
      e.exp = 8'h08;
      e.name = nm;
      sbQ.push_back(e);
      #1;
      popCheck();
      checkStall(16'd0, {nm, "_cnt"});
   endtask

   initial begin
      vecs[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'hC0, "idle"};
      vecs[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 8'h10, "lu_rs"};
      vecs[2] = '{5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'hC0, "bubble"};
      vecs[3] = '{5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 8'h10, "lu_rt"};
      vecs[4] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'hC0, "r0_load"};
      vecs[5] = '{5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 8'hC0, "no_match"};
      vecs[6] = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 8'hC0, "no_load"};
      vecs[7] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 8'hF0, "br_lu"};
      vecs[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 8'hF0, "branch"};
      vecs[9] = '{5'd0, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 8'h10, "lu_r31"};

      // reset state
      #2;
      resetNow("reset_state");
      @(negedge clock);
      reset = 1'b0;

      foreach (vecs[i])
         step(vecs[i].rs, vecs[i].rt, vecs[i].exRt, vecs[i].m2r,
              vecs[i].br, vecs[i].busy, vecs[i].exp, vecs[i].name);

      // memBusy for three cycles
      busyCyc(1'b0, 8'h08, "busy_c1");
      busyCyc(1'b0, 8'h09, "busy_c2");
      busyCyc(1'b0, 8'h09, "busy_c3");
      idle(8'hC1, "busy_drop");
      idle(8'hC0, "busy_run");

      // branch and load-use held through a freeze
      step(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 8'h08, "frz_br_c1");
      step(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 8'h09, "frz_br_c2");
      step(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 8'hF1, "frz_br_end");
      idle(8'hC0, "frz_after");

      // reset asserted mid MEM_WAIT
      busyCyc(1'b0, 8'h08, "rmw_c1");
      busyCyc(1'b0, 8'h09, "rmw_c2");
      resetNow("reset_mid_wait");
      #1;
      reset = 1'b0;
      memBusy = 1'b0;
      idle(8'hC0, "rmw_after");

      // timeout with TIMEOUT=4
      busyCyc(1'b0, 8'h08, "tmo_c1");
      for (int i = 2; i <= 5; i++)
         busyCyc(1'b0, 8'h09, $sformatf("tmo_c%0d", i));
      busyCyc(1'b0, 8'h0E, "tmo_fault");
      idle(8'h0E, "fault_sticky1");
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h0E, "fault_sticky2");
      resetNow("reset_fault");
      @(posedge clock);
      @(negedge clock);
      begin
         sb_t e;
         e.exp = 8'h08;
         e.name = "reset_held";
         sbQ.push_back(e);
         popCheck();
      end
      reset = 1'b0;
      idle(8'hC0, "post_fault");

`ifdef STALL_COUNTER_EN
      checkStall(16'd0, "cnt_clear");
      step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 8'h10, "cnt_lu1");
      idle(8'hC0, "cnt_b1");
      step(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 8'h10, "cnt_lu2");
      busyCyc(1'b0, 8'h08, "cnt_busy1");
      busyCyc(1'b0, 8'h09, "cnt_busy2");
      busyCyc(1'b0, 8'h09, "cnt_busy3");
      idle(8'hC1, "cnt_drop");
      checkStall(16'd5, "cnt_five");
      dut.stallCnt = 16'hFFFD;
      for (int i = 0; i < 4; i++)
         step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 8'h10, "cnt_sat_lu");
      idle(8'hC0, "cnt_sat_end");
      checkStall(16'hFFFF, "cnt_sat");
`else
      for (int i = 0; i < 3; i++)
         step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 8'h10, "nocnt_lu");
      busyCyc(1'b0, 8'h08, "nocnt_busy");
      idle(8'hC1, "nocnt_drop");
      checkStall(16'd0, "cnt_absent");
`endif

      checks++;
      if (sbQ.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: left %0d required 0", sbQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
